sand_brush_spawner: RTL and testbench

- Upstream stage of the game-state RAM write path: turns player buttons into sand deposits.
- Keeps a cursor position and moves it at a fixed repeat rate while a direction button is held.
- While the place button is held, writes a BRUSH_SIZE x BRUSH_SIZE square of sand cells (value 1) at the cursor.
- Writes are issued one cell per granted cycle through a req/gnt handshake with the game-state write arbiter, which interleaves them with the controller's own writes.

---
 rtl/falling_sand_pkg.sv | 15 +
 rtl/button_synchroniser.sv | 26 ++
 rtl/sand_brush_spawner.sv | 162 ++++++++++++++++
 tb/tb_sand_brush_spawner.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/falling_sand_pkg.sv
// rtl/falling_sand_pkg.sv - shared playfield constants and spawner state type
package falling_sand_pkg;

    localparam int DEFAULT_ACTIVE_COLUMNS = 640;
    localparam int DEFAULT_ACTIVE_ROWS    = 480;

    localparam logic CELL_EMPTY = 1'b0;
    localparam logic CELL_SAND  = 1'b1;

    typedef enum logic {
        IDLE,
        PAINT
    } spawner_state_e;

endpackage

// File: rtl/button_synchroniser.sv
// rtl/button_synchroniser.sv - N-bit two-flop synchroniser for raw button inputs
module button_synchroniser #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sand_brush_spawner.sv
// rtl/sand_brush_spawner.sv - tick-driven cursor and square sand brush feeding the RAM write arbiter
module sand_brush_spawner
    import falling_sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = DEFAULT_ACTIVE_COLUMNS,
    parameter int ACTIVE_ROWS    = DEFAULT_ACTIVE_ROWS,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int BRUSH_SIZE     = 4,
    parameter int MOVE_TICKS     = 1666666
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              btn_up_i,
    input  logic                              btn_down_i,
    input  logic                              btn_left_i,
    input  logic                              btn_right_i,
    input  logic                              btn_place_i,
    input  logic                              wr_gnt_i,
    output logic                              wr_req_o,
    output logic [ADDR_WIDTH-1:0]             ram_write_address_o,
    output logic [DATA_WIDTH-1:0]             ram_write_data_o,
    output logic [$clog2(ACTIVE_COLUMNS)-1:0] cursor_x_o,
    output logic [$clog2(ACTIVE_ROWS)-1:0]    cursor_y_o,
    output logic                              busy_o
);

    localparam int XW = $clog2(ACTIVE_COLUMNS);
    localparam int YW = $clog2(ACTIVE_ROWS);
    localparam int CW = $clog2(MOVE_TICKS);
    localparam int BW = $clog2(BRUSH_SIZE + 1);

    localparam logic [XW-1:0]         X_MAX     = XW'(ACTIVE_COLUMNS - BRUSH_SIZE);
    localparam logic [YW-1:0]         Y_MAX     = YW'(ACTIVE_ROWS - BRUSH_SIZE);
    localparam logic [BW-1:0]         LAST_CELL = BW'(BRUSH_SIZE - 1);
    localparam logic [CW-1:0]         LAST_CNT  = CW'(MOVE_TICKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(ACTIVE_COLUMNS);

    logic [4:0] btn_sync;
    logic       up, down, left, right, place;

    button_synchroniser #(
        .WIDTH(5)
    ) u_btn_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i ({btn_place_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i}),
        .sync_o  (btn_sync)
    );

    assign {place, right, left, down, up} = btn_sync;

    logic [CW-1:0] cnt_q;
    logic          tick;

    assign tick = (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

    spawner_state_e        state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [BW-1:0]         row_q, row_d;
    logic [BW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] cursor_base;

    assign cursor_base = ADDR_WIDTH'(y_q) * ROW_STEP + ADDR_WIDTH'(x_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        addr_d  = addr_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (right && !left && x_q < X_MAX) begin
                        x_d = x_q + XW'(1);
                    end else if (left && !right && x_q > '0) begin
                        x_d = x_q - XW'(1);
                    end
                    if (down && !up && y_q < Y_MAX) begin
                        y_d = y_q + YW'(1);
                    end else if (up && !down && y_q > '0) begin
                        y_d = y_q - YW'(1);
                    end
                    // Square anchors at the cursor as it was before this tick's move.
                    if (place) begin
                        state_d = PAINT;
                        row_d   = '0;
                        col_d   = '0;
                        base_d  = cursor_base;
                        addr_d  = cursor_base;
                        req_d   = 1'b1;
                    end
                end
            end
            PAINT: begin
                if (req_q && wr_gnt_i) begin
                    if (col_q == LAST_CELL) begin
                        if (row_q == LAST_CELL) begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end else begin
                            col_d  = '0;
                            row_d  = row_q + BW'(1);
                            base_d = base_q + ROW_STEP;
                            addr_d = base_q + ROW_STEP;
                        end
                    end else begin
                        col_d  = col_q + BW'(1);
                        addr_d = base_q + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_req_o            = req_q;
    assign ram_write_address_o = addr_q;
    assign ram_write_data_o    = DATA_WIDTH'(CELL_SAND);
    assign cursor_x_o          = x_q;
    assign cursor_y_o          = y_q;
    assign busy_o              = (state_q == PAINT);

endmodule

// File: tb/tb_sand_brush_spawner.sv
// tb/tb_sand_brush_spawner.sv - randomized bench for sand_brush_spawner against a behavioural model
module tb_sand_brush_spawner;

    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int AW   = $clog2(COLS * ROWS);
    localparam int B    = 2;
    localparam int MT   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    btn = '0;
    logic          gnt = 1'b0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [0:0]    wr_data;
    logic [3:0]    cur_x;
    logic [2:0]    cur_y;
    logic          busy;

    always #5 clk = ~clk;

    sand_brush_spawner #(
        .ACTIVE_COLUMNS(COLS),
        .ACTIVE_ROWS   (ROWS),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (1),
        .BRUSH_SIZE    (B),
        .MOVE_TICKS    (MT)
    ) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .btn_up_i            (btn[0]),
        .btn_down_i          (btn[1]),
        .btn_left_i          (btn[2]),
        .btn_right_i         (btn[3]),
        .btn_place_i         (btn[4]),
        .wr_gnt_i            (gnt),
        .wr_req_o            (wr_req),
        .ram_write_address_o (wr_addr),
        .ram_write_data_o    (wr_data),
        .cursor_x_o          (cur_x),
        .cursor_y_o          (cur_y),
        .busy_o              (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: cursor, tick phase, two-cycle button delay, remaining cells of the square.
    int         m_x, m_y, m_cnt, m_left, m_idx, m_px, m_py, m_writes;
    logic [4:0] m_s1, m_s2;
    int         obs_writes = 0;

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_cnt = 0; m_left = 0; m_idx = 0;
        m_s1 = '0; m_s2 = '0;
    endfunction

    function automatic int model_addr();
        return (m_py + m_idx / B) * COLS + m_px + m_idx % B;
    endfunction

    function automatic void model_step();
        bit         tick;
        logic [4:0] b;
        tick  = (m_cnt == MT - 1);
        m_cnt = (m_cnt + 1) % MT;
        b     = m_s2;
        if (m_left > 0) begin
            if (gnt) begin
                m_left--;
                m_idx++;
                m_writes++;
            end
        end else if (tick) begin
            if (b[4]) begin
                m_px = m_x; m_py = m_y; m_left = B * B; m_idx = 0;
            end
            if (b[3] && !b[2] && m_x < COLS - B) m_x++;
            else if (b[2] && !b[3] && m_x > 0) m_x--;
            if (b[1] && !b[0] && m_y < ROWS - B) m_y++;
            else if (b[0] && !b[1] && m_y > 0) m_y--;
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endfunction

    task automatic compare_all();
        check("req", int'(wr_req), int'(m_left > 0));
        check("busy", int'(busy), int'(m_left > 0));
        check("cursor_x", int'(cur_x), m_x);
        check("cursor_y", int'(cur_y), m_y);
        check("data", int'(wr_data), 1);
        if (m_left > 0) check("addr", int'(wr_addr), model_addr());
    endtask

    task automatic cycle();
        if (wr_req && gnt && !rst) obs_writes++;
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int hold;
    bit found;

    initial begin
        m_writes = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_req", int'(wr_req), 0);
        check("reset_addr", int'(wr_addr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_x", int'(cur_x), 0);
        rst = 1'b0;
        run(20);

        btn = 5'b01000;
        run(100);
        check("x_clamp_hi", int'(cur_x), COLS - B);
        btn = 5'b00100;
        run(90);
        check("x_clamp_lo", int'(cur_x), 0);
        btn = 5'b00011;
        run(40);

        btn  = 5'b01010;
        run(40);
        btn  = 5'b11010;
        gnt  = 1'b1;
        run(200);
        check("corner_x", int'(cur_x), COLS - B);
        check("corner_y", int'(cur_y), ROWS - B);

        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                btn  = 5'($urandom);
                hold = $urandom_range(1, 12);
            end
            hold--;
            gnt = ($urandom_range(0, 9) < 7);
            cycle();
        end

        btn = 5'b10000;
        gnt = 1'b1;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (m_left > 0 && m_idx == 2) found = 1;
        end
        check("midpaint_reached", int'(found), 1);
        btn = '0;
        rst = 1'b1;
        #1;
        check("async_req_drop", int'(wr_req), 0);
        check("async_busy_drop", int'(busy), 0);
        check("async_cursor_x", int'(cur_x), 0);
        model_reset();
        run(3);
        rst = 1'b0;
        run(30);

        check("write_count", obs_writes, m_writes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
